fifo_enqueue_arbiter: RTL and testbench

// Shares one sync_fifo write port between NUM_REQUESTERS producers. Each cycle
// it grants at most one requester by round-robin, registers the winner's value,
// and drives the FIFO enqueue one cycle later. Flow control uses the FIFO's

---
 rtl/fifo_enqueue_arbiter.sv | 85 ++++++++
 tb/tb_fifo_enqueue_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_enqueue_arbiter.sv
// fifo_enqueue_arbiter: round-robin arbiter that funnels NUM_REQUESTERS
// producers into the single write port of a sync_fifo. The winner's data is
// registered and written one cycle after the grant. The almost_full flag
// reserves room for the entry that is still in flight.
module fifo_enqueue_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int WIDTH          = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush_en,
    input  logic [NUM_REQUESTERS-1:0]       request,
    input  logic [NUM_REQUESTERS*WIDTH-1:0] value_i,
    output logic [NUM_REQUESTERS-1:0]       grant,
    input  logic                            fifo_full,
    input  logic                            fifo_almost_full,
    output logic                            fifo_enqueue_en,
    output logic [WIDTH-1:0]                fifo_value,
    output logic                            fifo_flush_en
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [NUM_REQUESTERS-1:0][WIDTH-1:0] lane_val;
    logic [IDX_W-1:0]                     last_grant;
    logic [IDX_W-1:0]                     win_idx;
    logic                                 win_found;
    logic                                 can_accept;
    logic                                 grant_vld;

    assign lane_val      = value_i;
    assign fifo_flush_en = flush_en;

    // A pending enqueue plus one more grant would overflow a FIFO at SIZE-1.
    // Reset also blocks grants because grant is combinational.
    assign can_accept = reset_n & ~flush_en & ~fifo_full
                      & ~(fifo_almost_full & fifo_enqueue_en);

    // Round-robin search that starts just after the last winner and wraps.
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQUESTERS;
            if (!win_found && request[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    assign grant_vld = can_accept & win_found;

    // Expand the winning index into a one-hot grant.
    always_comb begin
        grant = '0;
        if (grant_vld)
            grant[win_idx] = 1'b1;
    end

    // Capture the winner and issue the enqueue one cycle later. Idle and flush
    // cycles keep the data and pointer unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fifo_enqueue_en <= 1'b0;
            fifo_value      <= '0;
            last_grant      <= IDX_W'(NUM_REQUESTERS - 1);
        end else begin
            fifo_enqueue_en <= grant_vld;
            if (grant_vld) begin
                fifo_value <= lane_val[win_idx];
                last_grant <= win_idx;
            end
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot : assert property (@(posedge clk) $onehot0(grant));
    a_no_enq_full  : assert property (@(posedge clk) disable iff (!reset_n)
                                      !(fifo_enqueue_en && fifo_full));
`endif

endmodule

// File: tb/tb_fifo_enqueue_arbiter.sv
// Bench for fifo_enqueue_arbiter. A reference model tracks the round-robin
// pointer and a FIFO occupancy of SIZE entries. Expected grants are checked
// each cycle. Granted data goes into a scoreboard queue, and a separate monitor
// pops that queue whenever the DUT strobes fifo_enqueue_en.
module tb_fifo_enqueue_arbiter;
    localparam int N    = 4;
    localparam int W    = 64;
    localparam int SIZE = 4;

    logic           clk = 1'b0;
    logic           reset_n, flush_en;
    logic [N-1:0]   request, grant;
    logic [N*W-1:0] value_i;
    logic           fifo_full, fifo_almost_full, fifo_enqueue_en, fifo_flush_en;
    logic [W-1:0]   fifo_value;

    always #5 clk = ~clk;

    fifo_enqueue_arbiter #(.NUM_REQUESTERS(N), .WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .flush_en(flush_en), .request(request),
        .value_i(value_i), .grant(grant), .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full), .fifo_enqueue_en(fifo_enqueue_en),
        .fifo_value(fifo_value), .fifo_flush_en(fifo_flush_en)
    );

    int tests = 0;
    int fails = 0;

    // stimulus for the next cycle
    logic [N-1:0] req_v;
    logic         flush_v, rst_v, deq_v;
    logic [W-1:0] vals [N];

    // reference state
    int           last;
    int           fcount;
    bit           exp_enq;
    logic [W-1:0] exp_val;
    logic [W-1:0] sb [$];
    logic [W-1:0] sb_e;
    int           grants_seen;
    logic [N-1:0] act_grant;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester order after the last winner; first active one wins if there is room.
    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g = '0;
        if (!rst_v || flush_v || fcount >= SIZE || (fcount >= SIZE - 1 && exp_enq))
            return g;
        for (int k = 1; k <= N; k++) begin
            int i = (last + k) % N;
            if (req_v[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic step();
        logic [N-1:0] g;
        logic         enq_s;
        int           d, e;
        @(negedge clk);
        reset_n  = rst_v;
        flush_en = flush_v;
        request  = req_v;
        for (int i = 0; i < N; i++) value_i[i*W +: W] = vals[i];
        fifo_full        = (fcount >= SIZE);
        fifo_almost_full = (fcount >= SIZE - 1);
        #1;
        g = model_grant();
        act_grant = grant;
        chk("grant", grant, g);
        chk("enqueue_en", fifo_enqueue_en, exp_enq);
        chk("fifo_value_hold", fifo_value, exp_val);
        chk("flush_passthru", fifo_flush_en, flush_v);
        enq_s = fifo_enqueue_en;
        @(posedge clk);
        if (!rst_v) begin
            last = N - 1; exp_enq = 0; exp_val = '0; fcount = 0;
            sb.delete();
        end else begin
            if (flush_v) fcount = 0;
            else begin
                d = (deq_v && fcount > 0) ? 1 : 0;
                e = (enq_s === 1'b1 && fcount < SIZE) ? 1 : 0;
                fcount = fcount + e - d;
            end
            exp_enq = (g != '0);
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    exp_val = vals[i];
                    sb.push_back(vals[i]);
                    last = i;
                    grants_seen++;
                end
            end
        end
        // data may change only once the requester is idle or has been served
        for (int i = 0; i < N; i++)
            if (!req_v[i] || g[i]) vals[i] = rnd64();
    endtask

    // Monitor: every enqueue must carry the oldest granted value, never into a full FIFO.
    always @(negedge clk) begin
        #2;
        if (fifo_enqueue_en === 1'b1) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_underflow: enqueue of %0h with nothing granted", fifo_value);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_value", fifo_value, sb_e);
            end
            chk("no_enq_when_full", fifo_full, 1'b0);
        end
    end

    initial begin
        for (int i = 0; i < N; i++) vals[i] = rnd64();
        last = N - 1; fcount = 0; exp_enq = 0; exp_val = '0; grants_seen = 0;
        reset_n = 1'b0; flush_en = 1'b0; request = '0; value_i = '0;
        fifo_full = 1'b0; fifo_almost_full = 1'b0;
        req_v = '0; flush_v = 0; rst_v = 0; deq_v = 0;
        repeat (2) @(posedge clk);

        // 1: reset held with all requesting, then requester 0 goes first
        req_v = 4'b1111; deq_v = 1;
        repeat (3) step();
        rst_v = 1;
        step();
        chk("first_grant", act_grant, 4'b0001);

        // 2: fairness with everyone requesting, dequeuing to keep room
        repeat (8) step();
        step();                              // leaves last winner at 1
        chk("rr_next", act_grant, 4'b0010);

        // 3: sparse requests
        req_v = 4'b1010;
        step();
        chk("sparse_first", act_grant, 4'b1000);
        step();
        chk("sparse_second", act_grant, 4'b0010);
        repeat (4) step();

        // 4: back-pressure against a SIZE-entry FIFO with no dequeue
        req_v = '0; flush_v = 1; step();
        flush_v = 0; deq_v = 0; req_v = 4'b0001; grants_seen = 0;
        repeat (10) step();
        chk("bp_grants", 64'(grants_seen), 64'(SIZE));
        chk("bp_full", 64'(fcount), 64'(SIZE));
        chk("bp_blocked", act_grant, 4'b0000);
        deq_v = 1; step();
        deq_v = 0; grants_seen = 0;
        repeat (4) step();
        chk("bp_one_more", 64'(grants_seen), 64'd1);

        // 5: flush drops the in-flight entry
        req_v = '0; flush_v = 1; step();
        flush_v = 0; deq_v = 1; req_v = 4'b0001; step();
        chk("flush_pre_grant", act_grant, 4'b0001);
        flush_v = 1; step();
        chk("flush_no_grant", act_grant, 4'b0000);
        chk("flush_empty", 64'(fcount), 64'd0);
        flush_v = 0; req_v = '0; step();

        // 6: reset while an enqueue is in flight
        req_v = 4'b1111;
        repeat (3) step();
        rst_v = 0; step();
        rst_v = 1; step();
        chk("rst_mid_grant", act_grant, 4'b0001);

        // 7: random traffic
        for (int c = 0; c < 400; c++) begin
            req_v   = N'($urandom);
            flush_v = ($urandom_range(0, 19) == 0);
            rst_v   = ($urandom_range(0, 59) != 0);
            deq_v   = ($urandom_range(0, 2) != 0);
            step();
        end
        rst_v = 1; flush_v = 0; req_v = '0;
        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
